// File: rtl/sobel_stream_linebuf_if.sv
// Avalon-ST style pixel stream: data with packet framing and a valid/ready handshake.
interface sobel_stream_linebuf_if #(
  parameter int PIX_W = 8
);
  logic [PIX_W-1:0] data;
  logic             startofpacket;
  logic             endofpacket;
  logic             valid;
  logic             ready;

  modport master (output data, startofpacket, endofpacket, valid, input ready);
  modport slave  (input data, startofpacket, endofpacket, valid, output ready);
endinterface

// File: rtl/sobel_stream_linebuf.sv
// Streaming 3x3 Sobel filter: two line buffers, a sliding window and one output register.
// State | meaning: IDLE | waiting for SOP, other beats dropped; ACTIVE | inside a frame, counters advance.
module sobel_stream_linebuf #(
  parameter int PIX_W      = 8,
  parameter int IMG_X_SIZE = 320,
  parameter int IMG_Y_SIZE = 240
) (
  input  logic                  csi_clkrst_clk,
  input  logic                  csi_clkrst_reset_n,
  sobel_stream_linebuf_if.slave  asi_sink1,
  sobel_stream_linebuf_if.master aso_source1,
  input  logic                  mode_i,
  input  logic [PIX_W-1:0]      threshold_i,
  output logic                  frame_err_o
);
  localparam int XW = $clog2(IMG_X_SIZE);
  localparam int YW = $clog2(IMG_Y_SIZE);
  localparam int GW = PIX_W + 3;
  localparam logic [XW-1:0]    X_LAST  = XW'(IMG_X_SIZE - 1);
  localparam logic [YW-1:0]    Y_LAST  = YW'(IMG_Y_SIZE - 1);
  localparam logic [PIX_W-1:0] PIX_MAX = '1;

  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t r_state, w_state_nxt;

  logic [XW-1:0]    r_x, w_cx;
  logic [YW-1:0]    r_y, w_cy;
  logic             w_acc, w_sop, w_eop, w_proc, w_last, w_load, w_err;
  logic             r_valid, r_osop, r_oeop, r_err;
  logic [PIX_W-1:0] r_data;
  logic [PIX_W-1:0] r_lb0 [IMG_X_SIZE];
  logic [PIX_W-1:0] r_lb1 [IMG_X_SIZE];
  logic [PIX_W-1:0] r_ca [3];
  logic [PIX_W-1:0] r_cb [3];
  logic [PIX_W-1:0] w_n0, w_n1, w_n2, w_sat, w_thr, w_res;
  logic [GW-1:0]    w_sr, w_sl, w_sb, w_st, w_gx, w_gy, w_ax, w_ay, w_mag;

  assign asi_sink1.ready           = !r_valid || aso_source1.ready;
  assign aso_source1.valid         = r_valid;
  assign aso_source1.data          = r_data;
  assign aso_source1.startofpacket = r_osop;
  assign aso_source1.endofpacket   = r_oeop;
  assign frame_err_o               = r_err;

  assign w_acc  = asi_sink1.valid && asi_sink1.ready;
  assign w_sop  = asi_sink1.startofpacket;
  assign w_eop  = asi_sink1.endofpacket;
  assign w_proc = w_acc && (w_sop || (r_state == ACTIVE));
  // An SOP beat is always pixel (0,0), whatever the counters hold.
  assign w_cx   = w_sop ? '0 : r_x;
  assign w_cy   = w_sop ? '0 : r_y;
  assign w_last = (w_cx == X_LAST) && (w_cy == Y_LAST);
  assign w_load = w_proc && (w_cx >= XW'(2)) && (w_cy >= YW'(2));

  always_ff @(posedge csi_clkrst_clk) begin
    if (!csi_clkrst_reset_n) r_state <= IDLE;
    else                     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_err       = 1'b0;
    if (w_acc) begin
      if (w_sop) begin
        w_err       = (r_state == ACTIVE) || w_eop;
        w_state_nxt = w_eop ? IDLE : ACTIVE;
      end else if (r_state == ACTIVE) begin
        if (w_last) begin
          w_state_nxt = IDLE;
          w_err       = !w_eop;
        end else if (w_eop) begin
          w_state_nxt = IDLE;
          w_err       = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge csi_clkrst_clk) begin
    if (!csi_clkrst_reset_n) begin
      r_x <= '0;
      r_y <= '0;
    end else if (w_proc) begin
      if (w_cx == X_LAST) begin
        r_x <= '0;
        r_y <= w_cy + YW'(1);
      end else begin
        r_x <= w_cx + XW'(1);
        r_y <= w_cy;
      end
    end
  end

  // Row y-2 in r_lb0, row y-1 in r_lb1; columns x-2 / x-1 of the window in r_ca / r_cb.
  always_ff @(posedge csi_clkrst_clk) begin
    if (w_proc) begin
      r_lb0[w_cx] <= r_lb1[w_cx];
      r_lb1[w_cx] <= asi_sink1.data;
      r_ca[0] <= r_cb[0];
      r_ca[1] <= r_cb[1];
      r_ca[2] <= r_cb[2];
      r_cb[0] <= w_n0;
      r_cb[1] <= w_n1;
      r_cb[2] <= w_n2;
    end
  end

  always_comb begin
    w_n0  = r_lb0[w_cx];
    w_n1  = r_lb1[w_cx];
    w_n2  = asi_sink1.data;
    w_sr  = GW'(w_n0) + (GW'(w_n1) << 1) + GW'(w_n2);
    w_sl  = GW'(r_ca[0]) + (GW'(r_ca[1]) << 1) + GW'(r_ca[2]);
    w_sb  = GW'(r_ca[2]) + (GW'(r_cb[2]) << 1) + GW'(w_n2);
    w_st  = GW'(r_ca[0]) + (GW'(r_cb[0]) << 1) + GW'(w_n0);
    w_gx  = w_sr - w_sl;
    w_gy  = w_sb - w_st;
    w_ax  = w_gx[GW-1] ? (~w_gx + GW'(1)) : w_gx;
    w_ay  = w_gy[GW-1] ? (~w_gy + GW'(1)) : w_gy;
    w_mag = w_ax + w_ay;
    w_sat = (w_mag > GW'(PIX_MAX)) ? PIX_MAX : w_mag[PIX_W-1:0];
    w_thr = (w_mag >= GW'(threshold_i)) ? PIX_MAX : '0;
    w_res = mode_i ? w_thr : w_sat;
  end

  // A load can only happen while the sink is ready, so it never overwrites a stalled beat.
  always_ff @(posedge csi_clkrst_clk) begin
    if (!csi_clkrst_reset_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_osop  <= 1'b0;
      r_oeop  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_err <= w_err;
      if (w_load) begin
        r_valid <= 1'b1;
        r_data  <= w_res;
        r_osop  <= (w_cx == XW'(2)) && (w_cy == YW'(2));
        r_oeop  <= w_last;
      end else if (aso_source1.ready) begin
        r_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_sobel_stream_linebuf.sv
// Directed bench for sobel_stream_linebuf on an 8x6 frame with hand-computed results.
module tb_sobel_stream_linebuf;
  localparam int PW = 8;
  localparam int XS = 8;
  localparam int YS = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          mode = 1'b0;
  logic [PW-1:0] thr = '0;
  logic          ferr;

  sobel_stream_linebuf_if #(.PIX_W(PW)) snk ();
  sobel_stream_linebuf_if #(.PIX_W(PW)) src ();

  sobel_stream_linebuf #(.PIX_W(PW), .IMG_X_SIZE(XS), .IMG_Y_SIZE(YS)) dut (
    .csi_clkrst_clk    (clk),
    .csi_clkrst_reset_n(rst_n),
    .asi_sink1         (snk),
    .aso_source1       (src),
    .mode_i            (mode),
    .threshold_i       (thr),
    .frame_err_o       (ferr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [PW-1:0] q_d[$];
  bit            q_s[$], q_e[$];
  logic [PW-1:0] o_d[$];
  bit            o_s[$], o_e[$];
  int n_err, n_rdy_viol, n_rdy_low, n_stab_viol;

  // Expected vertical-edge output: each 6-wide output row reads 0,0,255,255,0,0.
  function automatic logic [PW-1:0] vpat(input int i);
    return ((i % 6) == 2 || (i % 6) == 3) ? 8'd255 : 8'd0;
  endfunction

  task automatic load_frame(input int kind);
    for (int y = 0; y < YS; y++)
      for (int x = 0; x < XS; x++) begin
        q_d.push_back((kind == 0) ? 8'd100 : ((x < 4) ? 8'd0 : 8'd255));
        q_s.push_back(x == 0 && y == 0);
        q_e.push_back(x == XS - 1 && y == YS - 1);
      end
  endtask

  task automatic clear_q();
    q_d.delete(); q_s.delete(); q_e.delete();
  endtask

  task automatic trim_q(input int n);
    while (q_d.size() > n) begin
      void'(q_d.pop_back()); void'(q_s.pop_back()); void'(q_e.pop_back());
    end
  endtask

  // Streams the queued beats; pat 0 keeps source ready high, pat 1 cycles ready 1,0,0,1.
  task automatic play(input int drain, input int pat);
    int idx = 0, cyc = 0, tail = 0;
    logic pv = 1'b0, pr = 1'b0, ps = 1'b0, pe = 1'b0;
    logic [PW-1:0] pd = '0;
    o_d.delete(); o_s.delete(); o_e.delete();
    n_err = 0; n_rdy_viol = 0; n_rdy_low = 0; n_stab_viol = 0;
    while ((idx < q_d.size() || tail < drain) && cyc < 2000) begin
      @(negedge clk);
      src.ready = (pat == 0) ? 1'b1 : ((cyc % 4) == 0 || (cyc % 4) == 3);
      if (idx < q_d.size()) begin
        snk.valid = 1'b1; snk.data = q_d[idx];
        snk.startofpacket = q_s[idx]; snk.endofpacket = q_e[idx];
      end else begin
        snk.valid = 1'b0; snk.startofpacket = 1'b0; snk.endofpacket = 1'b0;
        tail++;
      end
      #1;
      if (snk.ready !== (!src.valid || src.ready)) n_rdy_viol++;
      if (snk.ready !== 1'b1) n_rdy_low++;
      if (pv && !pr && (src.valid !== 1'b1 || src.data !== pd ||
                        src.startofpacket !== ps || src.endofpacket !== pe)) n_stab_viol++;
      pv = src.valid; pr = src.ready; pd = src.data;
      ps = src.startofpacket; pe = src.endofpacket;
      if (ferr === 1'b1) n_err++;
      if (src.valid === 1'b1 && src.ready === 1'b1) begin
        o_d.push_back(src.data); o_s.push_back(src.startofpacket); o_e.push_back(src.endofpacket);
      end
      if (snk.valid === 1'b1 && snk.ready === 1'b1) idx++;
      cyc++;
    end
    checks++;
    if (idx < q_d.size()) begin
      errors++;
      $display("FAIL play_timeout accepted %0d beats, required %0d", idx, q_d.size());
    end
    @(negedge clk);
    snk.valid = 1'b0; snk.startofpacket = 1'b0; snk.endofpacket = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; snk.valid = 1'b0; snk.data = '0;
    snk.startofpacket = 1'b0; snk.endofpacket = 1'b0; src.ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (src.valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", src.valid); end
    checks++; if (src.data !== 8'd0) begin errors++; $display("FAIL reset_data got %0d exp 0", src.data); end
    checks++; if (src.startofpacket !== 1'b0 || src.endofpacket !== 1'b0) begin
      errors++; $display("FAIL reset_sop_eop got %b%b exp 00", src.startofpacket, src.endofpacket); end
    checks++; if (ferr !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", ferr); end
    checks++; if (snk.ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", snk.ready); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_uniform();
    int nsop = 0, neop = 0, spos = -1, epos = -1;
    mode = 1'b0; clear_q(); load_frame(0); play(8, 0);
    checks++; if (o_d.size() != 24) begin errors++; $display("FAIL uniform_count got %0d exp 24", o_d.size()); end
    for (int i = 0; i < o_d.size(); i++) begin
      checks++; if (o_d[i] !== 8'd0) begin errors++; $display("FAIL uniform_data beat %0d got %0d exp 0", i, o_d[i]); end
      if (o_s[i]) begin nsop++; spos = i; end
      if (o_e[i]) begin neop++; epos = i; end
    end
    checks++; if (nsop != 1 || spos != 0) begin errors++; $display("FAIL uniform_sop count %0d at %0d exp 1 at 0", nsop, spos); end
    checks++; if (neop != 1 || epos != 23) begin errors++; $display("FAIL uniform_eop count %0d at %0d exp 1 at 23", neop, epos); end
    checks++; if (n_rdy_low != 0) begin errors++; $display("FAIL uniform_ready low cycles %0d exp 0", n_rdy_low); end
    checks++; if (n_err != 0) begin errors++; $display("FAIL uniform_err pulses %0d exp 0", n_err); end
  endtask

  task automatic test_vertical_mode0();
    int nsop = 0, neop = 0, spos = -1, epos = -1;
    mode = 1'b0; clear_q(); load_frame(1); play(8, 0);
    checks++; if (o_d.size() != 24) begin errors++; $display("FAIL vert0_count got %0d exp 24", o_d.size()); end
    for (int i = 0; i < o_d.size(); i++) begin
      checks++; if (o_d[i] !== vpat(i)) begin errors++; $display("FAIL vert0_data beat %0d got %0d exp %0d", i, o_d[i], vpat(i)); end
      if (o_s[i]) begin nsop++; spos = i; end
      if (o_e[i]) begin neop++; epos = i; end
    end
    checks++; if (nsop != 1 || spos != 0 || neop != 1 || epos != 23) begin
      errors++; $display("FAIL vert0_framing sop %0d@%0d eop %0d@%0d exp 1@0 1@23", nsop, spos, neop, epos); end
  endtask

  task automatic test_mode1();
    mode = 1'b1; thr = 8'd128; clear_q(); load_frame(1); play(8, 0);
    checks++; if (o_d.size() != 24) begin errors++; $display("FAIL thr128_count got %0d exp 24", o_d.size()); end
    for (int i = 0; i < o_d.size(); i++) begin
      checks++; if (o_d[i] !== vpat(i)) begin errors++; $display("FAIL thr128_data beat %0d got %0d exp %0d", i, o_d[i], vpat(i)); end
    end
    thr = 8'd0; clear_q(); load_frame(1); play(8, 0);
    checks++; if (o_d.size() != 24) begin errors++; $display("FAIL thr0_count got %0d exp 24", o_d.size()); end
    for (int i = 0; i < o_d.size(); i++) begin
      checks++; if (o_d[i] !== 8'd255) begin errors++; $display("FAIL thr0_data beat %0d got %0d exp 255", i, o_d[i]); end
    end
    mode = 1'b0; thr = 8'd0;
  endtask

  task automatic test_backpressure();
    int nsop = 0, neop = 0, spos = -1, epos = -1;
    mode = 1'b0; clear_q(); load_frame(1); play(8, 1);
    checks++; if (o_d.size() != 24) begin errors++; $display("FAIL bp_count got %0d exp 24", o_d.size()); end
    for (int i = 0; i < o_d.size(); i++) begin
      checks++; if (o_d[i] !== vpat(i)) begin errors++; $display("FAIL bp_data beat %0d got %0d exp %0d", i, o_d[i], vpat(i)); end
      if (o_s[i]) begin nsop++; spos = i; end
      if (o_e[i]) begin neop++; epos = i; end
    end
    checks++; if (nsop != 1 || spos != 0 || neop != 1 || epos != 23) begin
      errors++; $display("FAIL bp_framing sop %0d@%0d eop %0d@%0d exp 1@0 1@23", nsop, spos, neop, epos); end
    checks++; if (n_stab_viol != 0) begin errors++; $display("FAIL bp_stable changes while stalled %0d exp 0", n_stab_viol); end
    checks++; if (n_rdy_viol != 0) begin errors++; $display("FAIL bp_ready_rule violations %0d exp 0", n_rdy_viol); end
    checks++; if (n_rdy_low == 0) begin errors++; $display("FAIL bp_stalled sink ready low cycles %0d exp >0", n_rdy_low); end
  endtask

  task automatic test_framing();
    int neop = 0, epos = -1;
    // Beats before SOP, one of them carrying EOP, are silently dropped.
    clear_q();
    for (int j = 0; j < 5; j++) begin q_d.push_back(8'd255); q_s.push_back(1'b0); q_e.push_back(j == 3); end
    load_frame(1); play(8, 0);
    checks++; if (o_d.size() != 24) begin errors++; $display("FAIL presop_count got %0d exp 24", o_d.size()); end
    for (int i = 0; i < o_d.size(); i++) begin
      checks++; if (o_d[i] !== vpat(i)) begin errors++; $display("FAIL presop_data beat %0d got %0d exp %0d", i, o_d[i], vpat(i)); end
    end
    checks++; if (n_err != 0) begin errors++; $display("FAIL presop_err pulses %0d exp 0", n_err); end

    clear_q(); load_frame(1); trim_q(20); q_e[19] = 1'b1; play(8, 0);
    for (int i = 0; i < o_e.size(); i++) if (o_e[i]) neop++;
    checks++; if (n_err != 1) begin errors++; $display("FAIL early_eop_err pulses %0d exp 1", n_err); end
    checks++; if (neop != 0) begin errors++; $display("FAIL early_eop_out output eop count %0d exp 0", neop); end

    clear_q(); load_frame(1); play(8, 0);
    checks++; if (o_d.size() != 24) begin errors++; $display("FAIL after_err_count got %0d exp 24", o_d.size()); end
    for (int i = 0; i < o_d.size(); i++) begin
      checks++; if (o_d[i] !== vpat(i)) begin errors++; $display("FAIL after_err_data beat %0d got %0d exp %0d", i, o_d[i], vpat(i)); end
    end
    checks++; if (o_d.size() == 0 || o_s[0] !== 1'b1 || n_err != 0) begin
      errors++; $display("FAIL after_err_sop sop0 %0b err %0d exp 1 0", (o_s.size() > 0) ? o_s[0] : 1'b0, n_err); end

    clear_q(); load_frame(1); q_e[47] = 1'b0; play(8, 0);
    neop = 0;
    for (int i = 0; i < o_e.size(); i++) if (o_e[i]) begin neop++; epos = i; end
    checks++; if (n_err != 1) begin errors++; $display("FAIL no_eop_err pulses %0d exp 1", n_err); end
    checks++; if (o_d.size() != 24 || neop != 1 || epos != 23) begin
      errors++; $display("FAIL no_eop_out count %0d eop %0d@%0d exp 24 1@23", o_d.size(), neop, epos); end
  endtask

  task automatic test_reset_midframe();
    clear_q(); load_frame(1); trim_q(30); play(0, 0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (src.valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b exp 0", src.valid); end
    checks++; if (ferr !== 1'b0) begin errors++; $display("FAIL midrst_err got %b exp 0", ferr); end
    @(negedge clk);
    rst_n = 1'b1;
    // Non-SOP beats first: they are dropped only if the reset really returned to IDLE.
    clear_q();
    for (int j = 0; j < 2; j++) begin q_d.push_back(8'd255); q_s.push_back(1'b0); q_e.push_back(1'b0); end
    load_frame(1); play(8, 0);
    checks++; if (o_d.size() != 24) begin errors++; $display("FAIL midrst_count got %0d exp 24", o_d.size()); end
    for (int i = 0; i < o_d.size(); i++) begin
      checks++; if (o_d[i] !== vpat(i)) begin errors++; $display("FAIL midrst_data beat %0d got %0d exp %0d", i, o_d[i], vpat(i)); end
    end
    checks++; if (n_err != 0) begin errors++; $display("FAIL midrst_frame_err pulses %0d exp 0", n_err); end
  endtask

  initial begin
    test_reset();
    test_uniform();
    test_vertical_mode0();
    test_mode1();
    test_backpressure();
    test_framing();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end
endmodule
